atpg_vector_engine: RTL and testbench
=====================================

Name: atpg_vector_engine

Overview:
Synthesizable test-application engine that replaces hand-written per-vector fault benches.
- Holds up to DEPTH input vectors with their golden (fault-free) responses.
- Drives a fault-injectable DUT wrapper (e.g. c17 with NUM_SITES forceable nets) with one stuck-at fault selected for the whole run.
- Applies each vector, waits a settle time, and compares the DUT response with the golden response.
- Reports fail count, first failing vector index and first faulty response, and raises a detected flag.

Parameters:
NUM_IN, 5, DUT primary-input width
NUM_OUT, 2, DUT primary-output width
DEPTH, 16, vector/response memory entries (power of two, >=2)
SETTLE, 2, cycles between driving a vector and sampling the response (>=0)
NUM_SITES, 16, number of fault sites in the DUT wrapper
AW (derived), clog2(DEPTH), memory address width
SW (derived), clog2(NUM_SITES), fault-site select width

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
cfg_we  in  1  write vector/response entry
cfg_addr  in  AW  entry address
cfg_vec  in  NUM_IN  input vector to store
cfg_exp  in  NUM_OUT  golden response to store
num_vec  in  AW+1  vectors to apply this run, sampled at start
start  in  1  run request, single-cycle
fault_en_in  in  1  inject fault this run (0 = fault-free run)
fault_site_in  in  SW  fault site index
fault_val_in  in  1  stuck-at value
dut_in  out  NUM_IN  registered vector to DUT
dut_out  in  NUM_OUT  DUT response
fault_en  out  1  registered fault enable to wrapper
fault_site  out  SW  registered fault site
fault_val  out  1  registered stuck-at value
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of run
detected  out  1  fail_count!=0, valid from done until next start
fail_count  out  AW+1  mismatching vectors this run
first_fail_idx  out  AW  index of first mismatching vector
first_fail_resp  out  NUM_OUT  DUT response at first mismatch

Behaviour:
- Reset: all outputs 0, state IDLE, internal counters 0. Memory contents are not cleared. Reset mid-run aborts immediately; no done pulse is issued.
- Config: cfg_we writes vec_mem[cfg_addr] and exp_mem[cfg_addr] on the clock edge, only in IDLE or DONE. Writes while busy=1 are ignored.
- FSM states: IDLE, APPLY, WAIT, CAPTURE, DONE.
- IDLE, start=1:
  - Latch num_vec, clamped to DEPTH.
  - Latch fault_en/site/val into their registered outputs.
  - Clear fail_count, first_fail_idx, first_fail_resp and detected; set idx=0 and busy=1.
  - If the latched count = 0, go to DONE; else go to APPLY.
- APPLY: dut_in <= vec_mem[idx] and settle counter <= 0. Next state is WAIT if SETTLE>0, else CAPTURE.
- WAIT: count SETTLE cycles, then go to CAPTURE.
- CAPTURE: compare dut_out with exp_mem[idx].
  - On mismatch, fail_count++. If fail_count was 0, record first_fail_idx=idx and first_fail_resp=dut_out.
  - If idx = count-1, go to DONE; else idx++ and go to APPLY.
- DONE: done=1 and busy=0 for exactly this cycle; detected <= (fail_count!=0); return to IDLE.
  - Results and fault outputs hold until the next accepted start.
  - dut_in holds the last vector.
- Timing: each vector takes SETTLE+2 cycles. done is asserted N*(SETTLE+2)+1 cycles after the start edge, where N is the clamped count. A zero-count run pulses done on the cycle after start.
- start while busy=1 is ignored. start in the DONE cycle is ignored; it is accepted in IDLE only.
- fail_count saturates naturally: its width AW+1 holds DEPTH.
- cfg_we and start in the same IDLE cycle: the write completes and the run starts. The written entry is visible to APPLY on the following cycle.

Test Plan:
- Fault-free c17, vectors {00010, 10111} with expected {00, 10}, fault_en_in=0 -> done after 2*4+1=9 cycles; fail_count=0; detected=0.
- Same vectors, N10 stuck-at-1 -> vector 1 passes (N22=0); vector 2 gives N22=0 vs 1; fail_count=1, first_fail_idx=1, first_fail_resp=00, detected=1.
- num_vec=0 with start -> done exactly 1 cycle later; fail_count=0; dut_in unchanged.
- num_vec=DEPTH+5 with all expected responses deliberately wrong -> exactly DEPTH vectors applied; fail_count=DEPTH; first_fail_idx=0.
- Mid-run: start pulsed at cycle 3 and cfg_we at cycle 4 are both ignored, and memory is unchanged; rst at cycle 6 -> next cycle all outputs are 0, no done pulse, and a fresh start runs normally.
- SETTLE=0 build with 3 vectors -> done 7 cycles after start; capture occurs the cycle after APPLY.

Source files
------------

// File: rtl/atpg_vector_engine.sv
// atpg_vector_engine: applies stored vectors to a fault-injectable DUT
// wrapper, compares responses with golden values and reports failures.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cfg_we/addr/vec/exp      vector + golden response memory write
//   num_vec, start           run length (clamped to DEPTH) and run request
//   fault_en/site/val_in     fault selection latched at start
//   dut_in, dut_out          registered vector out, DUT response in
//   fault_en/site/val        registered fault controls to the wrapper
//   busy, done, detected     run status; done is a one-cycle pulse
//   fail_count               mismatching vectors this run
//   first_fail_idx/resp      index and response of the first mismatch
module atpg_vector_engine #(
    parameter  int NUM_IN    = 5,
    parameter  int NUM_OUT   = 2,
    parameter  int DEPTH     = 16,
    parameter  int SETTLE    = 2,
    parameter  int NUM_SITES = 16,
    localparam int AW        = $clog2(DEPTH),
    localparam int SW        = $clog2(NUM_SITES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [AW-1:0]      cfg_addr,
    input  logic [NUM_IN-1:0]  cfg_vec,
    input  logic [NUM_OUT-1:0] cfg_exp,
    input  logic [AW:0]        num_vec,
    input  logic               start,
    input  logic               fault_en_in,
    input  logic [SW-1:0]      fault_site_in,
    input  logic               fault_val_in,
    output logic [NUM_IN-1:0]  dut_in,
    input  logic [NUM_OUT-1:0] dut_out,
    output logic               fault_en,
    output logic [SW-1:0]      fault_site,
    output logic               fault_val,
    output logic               busy,
    output logic               done,
    output logic               detected,
    output logic [AW:0]        fail_count,
    output logic [AW-1:0]      first_fail_idx,
    output logic [NUM_OUT-1:0] first_fail_resp
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        WAIT,
        CAPTURE,
        DONE
    } state_e;

    logic [NUM_IN-1:0]  vec_mem [DEPTH];
    logic [NUM_OUT-1:0] exp_mem [DEPTH];

    state_e             state_q;
    logic [AW:0]        count_q;
    logic [AW-1:0]      idx_q;
    logic [CW-1:0]      cnt_q;
    logic [NUM_IN-1:0]  dut_in_q;
    logic               fault_en_q;
    logic [SW-1:0]      fault_site_q;
    logic               fault_val_q;
    logic               busy_q;
    logic               done_q;
    logic               detected_q;
    logic [AW:0]        fail_count_q;
    logic [AW-1:0]      first_fail_idx_q;
    logic [NUM_OUT-1:0] first_fail_resp_q;

    logic [AW:0] num_clamp_d;
    logic        mismatch_d;
    logic        last_d;
    logic        cfg_ok_d;

    always_comb begin
        num_clamp_d = num_vec;
        if (num_vec > (AW+1)'(DEPTH)) begin
            num_clamp_d = (AW+1)'(DEPTH);
        end
        mismatch_d = (dut_out != exp_mem[idx_q]);
        last_d     = ({1'b0, idx_q} == count_q - 1'b1);
        // Memory is only writable while no run owns it.
        cfg_ok_d   = cfg_we && (state_q == IDLE || state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (cfg_ok_d) begin
            vec_mem[cfg_addr] <= cfg_vec;
            exp_mem[cfg_addr] <= cfg_exp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= IDLE;
            count_q           <= '0;
            idx_q             <= '0;
            cnt_q             <= '0;
            dut_in_q          <= '0;
            fault_en_q        <= 1'b0;
            fault_site_q      <= '0;
            fault_val_q       <= 1'b0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            detected_q        <= 1'b0;
            fail_count_q      <= '0;
            first_fail_idx_q  <= '0;
            first_fail_resp_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        count_q           <= num_clamp_d;
                        fault_en_q        <= fault_en_in;
                        fault_site_q      <= fault_site_in;
                        fault_val_q       <= fault_val_in;
                        fail_count_q      <= '0;
                        first_fail_idx_q  <= '0;
                        first_fail_resp_q <= '0;
                        detected_q        <= 1'b0;
                        idx_q             <= '0;
                        busy_q            <= 1'b1;
                        state_q           <= (num_clamp_d == '0) ? DONE : APPLY;
                    end
                end
                APPLY: begin
                    dut_in_q <= vec_mem[idx_q];
                    cnt_q    <= '0;
                    state_q  <= (SETTLE > 0) ? WAIT : CAPTURE;
                end
                WAIT: begin
                    if (int'(cnt_q) >= SETTLE - 1) begin
                        state_q <= CAPTURE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                CAPTURE: begin
                    if (mismatch_d) begin
                        fail_count_q <= fail_count_q + 1'b1;
                        if (fail_count_q == '0) begin
                            first_fail_idx_q  <= idx_q;
                            first_fail_resp_q <= dut_out;
                        end
                    end
                    if (last_d) begin
                        state_q <= DONE;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= APPLY;
                    end
                end
                DONE: begin
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    detected_q <= (fail_count_q != '0);
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dut_in          = dut_in_q;
    assign fault_en        = fault_en_q;
    assign fault_site      = fault_site_q;
    assign fault_val       = fault_val_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign detected        = detected_q;
    assign fail_count      = fail_count_q;
    assign first_fail_idx  = first_fail_idx_q;
    assign first_fail_resp = first_fail_resp_q;

endmodule

// File: tb/tb_atpg_vector_engine.sv
// tb_atpg_vector_engine: drives the engine against a behavioural
// fault-injectable c17 and checks run results and timing.
module tb_atpg_vector_engine;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_we = 1'b0;
    logic [3:0] cfg_addr = '0;
    logic [4:0] cfg_vec = '0;
    logic [1:0] cfg_exp = '0;
    logic [4:0] num_vec = '0;
    logic       start = 1'b0;
    logic       start2 = 1'b0;
    logic       fault_en_in = 1'b0;
    logic [3:0] fault_site_in = '0;
    logic       fault_val_in = 1'b0;

    logic [4:0] dut_in, dut_in2;
    logic [1:0] dut_out, dut_out2;
    logic       fault_en, fault_en2, fault_val, fault_val2;
    logic [3:0] fault_site, fault_site2;
    logic       busy, busy2, done, done2, detected, detected2;
    logic [4:0] fail_count, fail_count2;
    logic [3:0] first_fail_idx, first_fail_idx2;
    logic [1:0] first_fail_resp, first_fail_resp2;

    logic [4:0] mvec [DEPTH];
    logic [1:0] mexp [DEPTH];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    function automatic logic fz(input logic x, input int s, input logic fe,
                                input logic [3:0] fs, input logic fv);
        return (fe && int'(fs) == s) ? fv : x;
    endfunction

    // c17 with site order N1 N2 N3 N6 N7 N10 N11 N16 N19 N22 N23
    function automatic logic [1:0] c17(input logic [4:0] v, input logic fe,
                                       input logic [3:0] fs, input logic fv);
        logic n1, n2, n3, n6, n7, n10, n11, n16, n19, n22, n23;
        n1  = fz(v[4], 0, fe, fs, fv);
        n2  = fz(v[3], 1, fe, fs, fv);
        n3  = fz(v[2], 2, fe, fs, fv);
        n6  = fz(v[1], 3, fe, fs, fv);
        n7  = fz(v[0], 4, fe, fs, fv);
        n10 = fz(~(n1 & n3), 5, fe, fs, fv);
        n11 = fz(~(n3 & n6), 6, fe, fs, fv);
        n16 = fz(~(n2 & n11), 7, fe, fs, fv);
        n19 = fz(~(n11 & n7), 8, fe, fs, fv);
        n22 = fz(~(n10 & n16), 9, fe, fs, fv);
        n23 = fz(~(n16 & n19), 10, fe, fs, fv);
        return {n22, n23};
    endfunction

    assign dut_out  = c17(dut_in, fault_en, fault_site, fault_val);
    assign dut_out2 = c17(dut_in2, fault_en2, fault_site2, fault_val2);

    atpg_vector_engine #(.SETTLE(2)) u_dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_vec(cfg_vec), .cfg_exp(cfg_exp), .num_vec(num_vec),
        .start(start), .fault_en_in(fault_en_in),
        .fault_site_in(fault_site_in), .fault_val_in(fault_val_in),
        .dut_in(dut_in), .dut_out(dut_out), .fault_en(fault_en),
        .fault_site(fault_site), .fault_val(fault_val), .busy(busy),
        .done(done), .detected(detected), .fail_count(fail_count),
        .first_fail_idx(first_fail_idx), .first_fail_resp(first_fail_resp)
    );

    atpg_vector_engine #(.SETTLE(0)) u_dut0 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_vec(cfg_vec), .cfg_exp(cfg_exp), .num_vec(num_vec),
        .start(start2), .fault_en_in(fault_en_in),
        .fault_site_in(fault_site_in), .fault_val_in(fault_val_in),
        .dut_in(dut_in2), .dut_out(dut_out2), .fault_en(fault_en2),
        .fault_site(fault_site2), .fault_val(fault_val2), .busy(busy2),
        .done(done2), .detected(detected2), .fail_count(fail_count2),
        .first_fail_idx(first_fail_idx2), .first_fail_resp(first_fail_resp2)
    );

    // Called on a falling edge; returns on the next falling edge.
    task automatic wr(input int a, input logic [4:0] v, input logic [1:0] e);
        cfg_we = 1'b1;
        cfg_addr = a[3:0];
        cfg_vec = v;
        cfg_exp = e;
        @(negedge clk);
        cfg_we = 1'b0;
        mvec[a] = v;
        mexp[a] = e;
    endtask

    // Returns the number of rising edges after the start edge at which
    // done was first seen high (bounded).
    task automatic run(input bit which, input int n, input logic fe,
                       input logic [3:0] fs, input logic fv, output int cyc);
        num_vec = n[4:0];
        fault_en_in = fe;
        fault_site_in = fs;
        fault_val_in = fv;
        if (which) start2 = 1'b1;
        else start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start2 = 1'b0;
        cyc = 0;
        while (!(which ? done2 : done) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic model(input int n, input logic fe, input logic [3:0] fs,
                         input logic fv, output int fc, output int fi,
                         output logic [1:0] fr);
        int m;
        logic [1:0] r;
        m = (n > DEPTH) ? DEPTH : n;
        fc = 0;
        fi = 0;
        fr = '0;
        for (int i = 0; i < m; i++) begin
            r = c17(mvec[i], fe, fs, fv);
            if (r != mexp[i]) begin
                if (fc == 0) begin
                    fi = i;
                    fr = r;
                end
                fc++;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({busy, done, detected, fail_count} !== '0) begin
            fails++;
            $display("FAIL reset_status got %b exp 0",
                     {busy, done, detected, fail_count});
        end
        tests++;
        if ({dut_in, fault_en, fault_site, fault_val} !== '0) begin
            fails++;
            $display("FAIL reset_drive got %b exp 0",
                     {dut_in, fault_en, fault_site, fault_val});
        end
        tests++;
        if ({first_fail_idx, first_fail_resp, busy2, done2} !== '0) begin
            fails++;
            $display("FAIL reset_first got %b exp 0",
                     {first_fail_idx, first_fail_resp, busy2, done2});
        end
    endtask

    task automatic test_fault_free();
        int cyc;
        wr(0, 5'b00010, 2'b00);
        wr(1, 5'b10111, 2'b10);
        run(0, 2, 1'b0, 4'd0, 1'b0, cyc);
        tests++;
        if (cyc != 9) begin
            fails++;
            $display("FAIL ff_latency got %0d exp 9", cyc);
        end
        tests++;
        if (fail_count !== 5'd0 || detected !== 1'b0) begin
            fails++;
            $display("FAIL ff_result got %0d/%b exp 0/0", fail_count, detected);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL ff_pulse got done %b busy %b exp 0 0", done, busy);
        end
    endtask

    task automatic test_n10_sa1();
        int cyc;
        run(0, 2, 1'b1, 4'd5, 1'b1, cyc);
        tests++;
        if (cyc != 9) begin
            fails++;
            $display("FAIL sa1_latency got %0d exp 9", cyc);
        end
        tests++;
        if (fail_count !== 5'd1 || first_fail_idx !== 4'd1) begin
            fails++;
            $display("FAIL sa1_count got %0d/%0d exp 1/1",
                     fail_count, first_fail_idx);
        end
        tests++;
        if (first_fail_resp !== 2'b00 || detected !== 1'b1) begin
            fails++;
            $display("FAIL sa1_resp got %b/%b exp 00/1",
                     first_fail_resp, detected);
        end
        tests++;
        if ({fault_en, fault_site, fault_val} !== {1'b1, 4'd5, 1'b1}) begin
            fails++;
            $display("FAIL sa1_fault got %b exp 1_0101_1",
                     {fault_en, fault_site, fault_val});
        end
    endtask

    task automatic test_zero();
        int cyc;
        run(0, 0, 1'b0, 4'd3, 1'b0, cyc);
        tests++;
        if (cyc != 1) begin
            fails++;
            $display("FAIL zero_latency got %0d exp 1", cyc);
        end
        tests++;
        if (fail_count !== 5'd0 || detected !== 1'b0) begin
            fails++;
            $display("FAIL zero_result got %0d/%b exp 0/0", fail_count, detected);
        end
        tests++;
        if (dut_in !== 5'b10111) begin
            fails++;
            $display("FAIL zero_dut_in got %b exp 10111", dut_in);
        end
    endtask

    task automatic test_clamp();
        int cyc;
        logic [4:0] v;
        for (int i = 0; i < DEPTH; i++) begin
            v = 5'($urandom);
            wr(i, v, ~c17(v, 1'b0, 4'd0, 1'b0));
        end
        run(0, DEPTH + 5, 1'b0, 4'd0, 1'b0, cyc);
        tests++;
        if (cyc != DEPTH * 4 + 1) begin
            fails++;
            $display("FAIL clamp_latency got %0d exp %0d", cyc, DEPTH * 4 + 1);
        end
        tests++;
        if (fail_count !== 5'(DEPTH) || first_fail_idx !== 4'd0) begin
            fails++;
            $display("FAIL clamp_count got %0d/%0d exp %0d/0",
                     fail_count, first_fail_idx, DEPTH);
        end
        tests++;
        if (first_fail_resp !== c17(mvec[0], 1'b0, 4'd0, 1'b0)) begin
            fails++;
            $display("FAIL clamp_resp got %b exp %b", first_fail_resp,
                     c17(mvec[0], 1'b0, 4'd0, 1'b0));
        end
    endtask

    task automatic test_random();
        int cyc, n, fc, fi, ecyc;
        logic [1:0] fr;
        logic [4:0] v;
        logic fe, fv;
        logic [3:0] fs;
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < DEPTH; i++) begin
                v = 5'($urandom);
                wr(i, v, ($urandom_range(0, 3) == 0) ? 2'($urandom)
                                                     : c17(v, 1'b0, 4'd0, 1'b0));
            end
            n = $urandom_range(0, 19);
            fe = 1'($urandom);
            fs = 4'($urandom_range(0, 15));
            fv = 1'($urandom);
            model(n, fe, fs, fv, fc, fi, fr);
            ecyc = ((n > DEPTH) ? DEPTH : n) * 4 + 1;
            run(0, n, fe, fs, fv, cyc);
            tests++;
            if (cyc != ecyc) begin
                fails++;
                $display("FAIL rnd%0d_latency got %0d exp %0d", it, cyc, ecyc);
            end
            tests++;
            if (int'(fail_count) != fc || int'(first_fail_idx) != fi) begin
                fails++;
                $display("FAIL rnd%0d_count got %0d/%0d exp %0d/%0d",
                         it, fail_count, first_fail_idx, fc, fi);
            end
            tests++;
            if (first_fail_resp !== fr || detected !== (fc != 0)) begin
                fails++;
                $display("FAIL rnd%0d_resp got %b/%b exp %b/%b", it,
                         first_fail_resp, detected, fr, fc != 0);
            end
        end
    endtask

    task automatic test_midrun();
        int cyc, fc, fi;
        logic [1:0] fr;
        bit seen;
        wr(0, 5'b10111, 2'b10);
        wr(1, 5'b00010, 2'b01);
        wr(2, 5'b11111, 2'b11);
        wr(3, 5'b01101, 2'b00);
        num_vec = 5'd4;
        fault_en_in = 1'b1;
        fault_site_in = 4'd5;
        fault_val_in = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k <= 6; k++) begin
            if (done) seen = 1'b1;
            if (k == 2) begin
                num_vec = 5'd0;
                start = 1'b1;
            end
            if (k == 3) begin
                start = 1'b0;
                cfg_we = 1'b1;
                cfg_addr = 4'd0;
                cfg_vec = mvec[0];
                cfg_exp = ~mexp[0];
            end
            if (k == 4) cfg_we = 1'b0;
            if (k == 5) begin
                tests++;
                if (busy !== 1'b1) begin
                    fails++;
                    $display("FAIL mid_busy got %b exp 1", busy);
                end
                rst = 1'b1;
            end
            if (k < 6) @(negedge clk);
        end
        tests++;
        if (seen) begin
            fails++;
            $display("FAIL mid_no_done got 1 exp 0");
        end
        tests++;
        if ({busy, done, detected, fail_count, first_fail_idx,
             first_fail_resp} !== '0) begin
            fails++;
            $display("FAIL mid_reset_status got %b exp 0", {busy, done,
                     detected, fail_count, first_fail_idx, first_fail_resp});
        end
        tests++;
        if ({dut_in, fault_en, fault_site, fault_val} !== '0) begin
            fails++;
            $display("FAIL mid_reset_drive got %b exp 0",
                     {dut_in, fault_en, fault_site, fault_val});
        end
        rst = 1'b0;
        @(negedge clk);
        model(4, 1'b0, 4'd0, 1'b0, fc, fi, fr);
        run(0, 4, 1'b0, 4'd0, 1'b0, cyc);
        tests++;
        if (cyc != 17) begin
            fails++;
            $display("FAIL mid_fresh_latency got %0d exp 17", cyc);
        end
        tests++;
        if (int'(fail_count) != fc || int'(first_fail_idx) != fi ||
            first_fail_resp !== fr) begin
            fails++;
            $display("FAIL mid_fresh_result got %0d/%0d/%b exp %0d/%0d/%b",
                     fail_count, first_fail_idx, first_fail_resp, fc, fi, fr);
        end
    endtask

    task automatic test_settle0();
        int cyc, fc, fi;
        logic [1:0] fr;
        logic [4:0] v;
        for (int i = 0; i < 3; i++) begin
            v = 5'($urandom);
            wr(i, v, (i == 1) ? ~c17(v, 1'b1, 4'd9, 1'b0)
                              : c17(v, 1'b1, 4'd9, 1'b0));
        end
        model(3, 1'b1, 4'd9, 1'b0, fc, fi, fr);
        run(1, 3, 1'b1, 4'd9, 1'b0, cyc);
        tests++;
        if (cyc != 7) begin
            fails++;
            $display("FAIL s0_latency got %0d exp 7", cyc);
        end
        tests++;
        if (int'(fail_count2) != fc || int'(first_fail_idx2) != fi ||
            first_fail_resp2 !== fr || detected2 !== (fc != 0)) begin
            fails++;
            $display("FAIL s0_result got %0d/%0d/%b/%b exp %0d/%0d/%b/%b",
                     fail_count2, first_fail_idx2, first_fail_resp2,
                     detected2, fc, fi, fr, fc != 0);
        end
    endtask

    initial begin
        test_reset();
        test_fault_free();
        test_n10_sa1();
        test_zero();
        test_clamp();
        test_random();
        test_midrun();
        test_settle0();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
